// File: rtl/cpu_pkg.sv
// Shared definitions for the Rv32H core: RV32I opcodes, the decoded
// operation class and the decode-stage state encoding.
package cpu_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int REG_IDX_W_DEF = 5;

  // RV32I major opcodes (instruction bits 6:0)
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    OP_ALU_R   = 4'd0,
    OP_ALU_I   = 4'd1,
    OP_LOAD    = 4'd2,
    OP_STORE   = 4'd3,
    OP_BRANCH  = 4'd4,
    OP_JAL     = 4'd5,
    OP_JALR    = 4'd6,
    OP_LUI     = 4'd7,
    OP_AUIPC   = 4'd8,
    OP_FENCE   = 4'd9,
    OP_SYSTEM  = 4'd10,
    OP_ILLEGAL = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_e;

  // Map a full 7-bit opcode to its class. Every legal opcode ends in 2'b11,
  // so a compressed-style encoding (bits 1:0 != 11) also lands in ILLEGAL.
  function automatic op_e opcode_class(input logic [6:0] opc);
    op_e cls;
    case (opc)
      OPC_OP:       cls = OP_ALU_R;
      OPC_OP_IMM:   cls = OP_ALU_I;
      OPC_LOAD:     cls = OP_LOAD;
      OPC_STORE:    cls = OP_STORE;
      OPC_BRANCH:   cls = OP_BRANCH;
      OPC_JAL:      cls = OP_JAL;
      OPC_JALR:     cls = OP_JALR;
      OPC_LUI:      cls = OP_LUI;
      OPC_AUIPC:    cls = OP_AUIPC;
      OPC_MISC_MEM: cls = OP_FENCE;
      OPC_SYSTEM:   cls = OP_SYSTEM;
      default:      cls = OP_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/cpu_decode_imm.sv
// Immediate generator: rebuilds the RV32I I/S/B/U/J immediate for the given
// op class from instruction bits 31:7 and sign-extends bit 31 to XLEN.
// Formats without an immediate (R, illegal) return 0.
module cpu_decode_imm
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:7]     i_instruction,
  input  op_e             i_op,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] imm32;

  // Select the bit layout of the immediate from the instruction format
  always_comb begin
    imm32 = '0;
    case (i_op)
      OP_ALU_I, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM:
        imm32 = {{20{i_instruction[31]}}, i_instruction[31:20]};
      OP_STORE:
        imm32 = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
      OP_BRANCH:
        imm32 = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                 i_instruction[30:25], i_instruction[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {i_instruction[31:12], 12'b0};
      OP_JAL:
        imm32 = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                 i_instruction[20], i_instruction[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  assign o_imm = XLEN'($signed(imm32));

endmodule

// File: rtl/cpu_decode.sv
// Decode stage of the Rv32H core. Accepts one instruction from fetch, reads
// rs1/rs2 from the register file (data returns one cycle after o_read), then
// presents a registered decoded bundle to execute.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1. Valid, once raised, holds with its payload stable until that
// edge; ready may depend combinationally on the other side's valid/ready.
// i_flush overrides both transfers on its edge.
//
// Optional build macro CPU_DECODE_FORWARD_EN adds a writeback bypass port;
// a matching writeback at the capture edge replaces the register file data.
module cpu_decode
  import cpu_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int REG_IDX_W = REG_IDX_W_DEF
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_flush,
  input  logic                 i_fetch_valid,
  output logic                 o_fetch_ready,
  input  logic [31:0]          i_fetch_instruction,
  input  logic [XLEN-1:0]      i_fetch_pc,
  output logic                 o_read,
  output logic [REG_IDX_W-1:0] o_read_rs1_idx,
  output logic [REG_IDX_W-1:0] o_read_rs2_idx,
  input  logic [XLEN-1:0]      i_rs1,
  input  logic [XLEN-1:0]      i_rs2,
  output logic                 o_exec_valid,
  input  logic                 i_exec_ready,
  output logic [XLEN-1:0]      o_exec_pc,
  output logic [XLEN-1:0]      o_exec_rs1,
  output logic [XLEN-1:0]      o_exec_rs2,
  output logic [XLEN-1:0]      o_exec_imm,
  output logic [REG_IDX_W-1:0] o_exec_rd_idx,
  output logic [2:0]           o_exec_funct3,
  output logic                 o_exec_funct7b5,
  output logic [3:0]           o_exec_op,
  output logic                 o_exec_illegal,
`ifdef CPU_DECODE_FORWARD_EN
  input  logic                 i_wb_valid,
  input  logic [REG_IDX_W-1:0] i_wb_rd_idx,
  input  logic [XLEN-1:0]      i_wb_rd,
`endif
  output logic [1:0]           o_dbg_state
);

  state_e                 state;
  logic [31:0]            instr_q;
  logic [XLEN-1:0]        pc_q;

  logic                   fetch_accept;
  op_e                    op_c;
  logic [REG_IDX_W-1:0]   rd_c;
  logic [XLEN-1:0]        imm_c;
  logic [XLEN-1:0]        rs1_src;
  logic [XLEN-1:0]        rs2_src;

  // Ready in IDLE, or in OUTPUT when this edge also hands the bundle off;
  // held low during reset and on a flush edge so fetch never sees an accept.
  assign o_fetch_ready = i_reset_n && !i_flush &&
                         ((state == ST_IDLE) || ((state == ST_OUTPUT) && i_exec_ready));
  assign fetch_accept  = o_fetch_ready && i_fetch_valid;
  assign o_dbg_state   = state;

  assign op_c = opcode_class(instr_q[6:0]);

  // Destination index: formats with no rd (S, B, unknown) report x0
  always_comb begin
    rd_c = instr_q[11:7];
    if (op_c == OP_STORE || op_c == OP_BRANCH || op_c == OP_ILLEGAL) begin
      rd_c = '0;
    end
  end

  cpu_decode_imm #(.XLEN(XLEN)) u_imm (
    .i_instruction (instr_q[31:7]),
    .i_op          (op_c),
    .o_imm         (imm_c)
  );

  // Operand select: x0 is always zero, else register file or bypassed writeback
  always_comb begin
    rs1_src = (o_read_rs1_idx == '0) ? '0 : i_rs1;
    rs2_src = (o_read_rs2_idx == '0) ? '0 : i_rs2;
`ifdef CPU_DECODE_FORWARD_EN
    if (i_wb_valid && (i_wb_rd_idx == o_read_rs1_idx) && (o_read_rs1_idx != '0)) begin
      rs1_src = i_wb_rd;
    end
    if (i_wb_valid && (i_wb_rd_idx == o_read_rs2_idx) && (o_read_rs2_idx != '0)) begin
      rs2_src = i_wb_rd;
    end
`endif
  end

  // Decode FSM: IDLE -> READ -> CAPTURE -> OUTPUT, with all outputs registered
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state           <= ST_IDLE;
      instr_q         <= '0;
      pc_q            <= '0;
      o_read          <= 1'b0;
      o_read_rs1_idx  <= '0;
      o_read_rs2_idx  <= '0;
      o_exec_valid    <= 1'b0;
      o_exec_pc       <= '0;
      o_exec_rs1      <= '0;
      o_exec_rs2      <= '0;
      o_exec_imm      <= '0;
      o_exec_rd_idx   <= '0;
      o_exec_funct3   <= '0;
      o_exec_funct7b5 <= 1'b0;
      o_exec_op       <= '0;
      o_exec_illegal  <= 1'b0;
    end else if (i_flush) begin
      state        <= ST_IDLE;
      o_read       <= 1'b0;
      o_exec_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_IDLE;
        end
        ST_READ: begin
          o_read <= 1'b0;
          state  <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          o_exec_pc       <= pc_q;
          o_exec_rs1      <= rs1_src;
          o_exec_rs2      <= rs2_src;
          o_exec_imm      <= imm_c;
          o_exec_rd_idx   <= rd_c;
          o_exec_funct3   <= instr_q[14:12];
          o_exec_funct7b5 <= instr_q[30];
          o_exec_op       <= op_c;
          o_exec_illegal  <= (op_c == OP_ILLEGAL);
          o_exec_valid    <= 1'b1;
          state           <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (i_exec_ready) begin
            o_exec_valid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A new instruction (possibly on the handoff edge) always starts a read
      if (fetch_accept) begin
        instr_q        <= i_fetch_instruction;
        pc_q           <= i_fetch_pc;
        o_read_rs1_idx <= i_fetch_instruction[19:15];
        o_read_rs2_idx <= i_fetch_instruction[24:20];
        o_read         <= 1'b1;
        state          <= ST_READ;
      end
    end
  end

endmodule

// File: tb/tb_cpu_decode.sv
// Bench for cpu_decode: directed scenarios plus randomized traffic, with a
// scoreboard fed by the fetch driver and drained by an output monitor.
module tb_cpu_decode;
  import cpu_pkg::*;

  localparam int W = 142;

  logic        i_clock, i_reset_n, i_flush;
  logic        i_fetch_valid, o_fetch_ready;
  logic [31:0] i_fetch_instruction, i_fetch_pc;
  logic        o_read;
  logic [4:0]  o_read_rs1_idx, o_read_rs2_idx;
  logic [31:0] i_rs1, i_rs2;
  logic        o_exec_valid, i_exec_ready;
  logic [31:0] o_exec_pc, o_exec_rs1, o_exec_rs2, o_exec_imm;
  logic [4:0]  o_exec_rd_idx;
  logic [2:0]  o_exec_funct3;
  logic        o_exec_funct7b5;
  logic [3:0]  o_exec_op;
  logic        o_exec_illegal;
  logic [1:0]  o_dbg_state;
`ifdef CPU_DECODE_FORWARD_EN
  logic        i_wb_valid;
  logic [4:0]  i_wb_rd_idx;
  logic [31:0] i_wb_rd;
`endif

  logic [W-1:0] exp_q[$];
  logic [31:0]  regs [0:31];
  int           n_checks, n_pass;
  int           rdy_mode;  // 0: ready low, 1: random, 2: ready high

  cpu_decode dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_flush(i_flush),
    .i_fetch_valid(i_fetch_valid), .o_fetch_ready(o_fetch_ready),
    .i_fetch_instruction(i_fetch_instruction), .i_fetch_pc(i_fetch_pc),
    .o_read(o_read), .o_read_rs1_idx(o_read_rs1_idx), .o_read_rs2_idx(o_read_rs2_idx),
    .i_rs1(i_rs1), .i_rs2(i_rs2),
    .o_exec_valid(o_exec_valid), .i_exec_ready(i_exec_ready),
    .o_exec_pc(o_exec_pc), .o_exec_rs1(o_exec_rs1), .o_exec_rs2(o_exec_rs2),
    .o_exec_imm(o_exec_imm), .o_exec_rd_idx(o_exec_rd_idx),
    .o_exec_funct3(o_exec_funct3), .o_exec_funct7b5(o_exec_funct7b5),
    .o_exec_op(o_exec_op), .o_exec_illegal(o_exec_illegal),
`ifdef CPU_DECODE_FORWARD_EN
    .i_wb_valid(i_wb_valid), .i_wb_rd_idx(i_wb_rd_idx), .i_wb_rd(i_wb_rd),
`endif
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pack(input logic [31:0] pc, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] imm,
                                        input logic [4:0] rd, input logic [2:0] f3,
                                        input logic f7, input logic [3:0] op,
                                        input logic ill);
    return {pc, a, b, imm, rd, f3, f7, op, ill};
  endfunction

  function automatic logic [W-1:0] dut_bundle();
    return pack(o_exec_pc, o_exec_rs1, o_exec_rs2, o_exec_imm, o_exec_rd_idx,
                o_exec_funct3, o_exec_funct7b5, o_exec_op, o_exec_illegal);
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
  endtask

  // Reference decoder: format table plus arithmetic assembly of immediates
  function automatic logic [W-1:0] model(input logic [31:0] ins, input logic [31:0] pc);
    logic [31:0] sgn, imm, v1, v2;
    logic [4:0]  rd, a, b;
    op_e         op;
    byte         fmt;
    sgn = {32{ins[31]}};
    case (ins[6:0])
      7'h33:   begin op = OP_ALU_R;   fmt = "R"; end
      7'h13:   begin op = OP_ALU_I;   fmt = "I"; end
      7'h03:   begin op = OP_LOAD;    fmt = "I"; end
      7'h23:   begin op = OP_STORE;   fmt = "S"; end
      7'h63:   begin op = OP_BRANCH;  fmt = "B"; end
      7'h6F:   begin op = OP_JAL;     fmt = "J"; end
      7'h67:   begin op = OP_JALR;    fmt = "I"; end
      7'h37:   begin op = OP_LUI;     fmt = "U"; end
      7'h17:   begin op = OP_AUIPC;   fmt = "U"; end
      7'h0F:   begin op = OP_FENCE;   fmt = "I"; end
      7'h73:   begin op = OP_SYSTEM;  fmt = "I"; end
      default: begin op = OP_ILLEGAL; fmt = "X"; end
    endcase
    case (fmt)
      "I": imm = (sgn << 12) | 32'(ins[31:20]);
      "S": imm = (sgn << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
      "B": imm = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      "U": imm = ins & 32'hFFFF_F000;
      "J": imm = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      default: imm = 32'h0;
    endcase
    rd = (fmt == "S" || fmt == "B" || fmt == "X") ? 5'd0 : ins[11:7];
    a  = ins[19:15];
    b  = ins[24:20];
    v1 = (a == 0) ? 32'h0 : regs[a];
    v2 = (b == 0) ? 32'h0 : regs[b];
`ifdef CPU_DECODE_FORWARD_EN
    if (i_wb_valid && i_wb_rd_idx == a && a != 0) v1 = i_wb_rd;
    if (i_wb_valid && i_wb_rd_idx == b && b != 0) v2 = i_wb_rd;
`endif
    return pack(pc, v1, v2, imm, rd, ins[14:12], ins[30], op, (op == OP_ILLEGAL));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [0:10];
    logic [31:0] w;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = opcs[$urandom_range(0, 10)];
    return w;
  endfunction

  // ---------------- register file model ----------------
  logic       rf_rd_s;
  logic [4:0] rf_a_s, rf_b_s;
  always @(negedge i_clock) begin
    rf_rd_s = o_read;
    rf_a_s  = o_read_rs1_idx;
    rf_b_s  = o_read_rs2_idx;
  end
  // Data for a read appears the cycle after o_read; junk otherwise
  always @(posedge i_clock) begin
    #1;
    if (rf_rd_s) begin
      i_rs1 = regs[rf_a_s];
      i_rs2 = regs[rf_b_s];
    end else begin
      i_rs1 = $urandom;
      i_rs2 = $urandom;
    end
  end

  // ---------------- execute-side ready driver ----------------
  initial begin
    i_exec_ready = 1'b0;
    forever begin
      @(posedge i_clock);
      #1;
      case (rdy_mode)
        1:       i_exec_ready = 1'($urandom_range(0, 1));
        2:       i_exec_ready = 1'b1;
        default: i_exec_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic [W-1:0] last_act;
  bit           held;
  always @(negedge i_clock) begin
    if (!i_reset_n) begin
      held = 0;
    end else if (o_exec_valid) begin
      if (held) chk("hold_stable", dut_bundle(), last_act);
      if (i_exec_ready && !i_flush) begin
        chk("sb_nonempty", W'(exp_q.size() != 0), W'(1));
        if (exp_q.size() != 0) chk("bundle", dut_bundle(), exp_q.pop_front());
        held = 0;
      end else begin
        held     = 1;
        last_act = dut_bundle();
      end
    end else begin
      held = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input bit expect_out);
    int n;
    n = 0;
    @(posedge i_clock);
    #1;
    i_fetch_instruction = ins;
    i_fetch_pc          = pc;
    i_fetch_valid       = 1'b1;
    forever begin
      @(negedge i_clock);
      if (o_fetch_ready) break;
      n++;
      if (n > 300) break;
    end
    if (n > 300) begin
      chk("send_timeout", W'(0), W'(1));
    end else if (expect_out) begin
      exp_q.push_back(model(ins, pc));
    end
    @(posedge i_clock);
    #1;
    i_fetch_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge i_clock);
      n++;
    end
    chk("drain", W'(exp_q.size()), W'(0));
    exp_q.delete();
    @(posedge i_clock);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0; n_pass = 0; rdy_mode = 0;
    i_reset_n = 1'b1; i_flush = 1'b0; i_fetch_valid = 1'b0;
    i_fetch_instruction = '0; i_fetch_pc = '0; i_rs1 = '0; i_rs2 = '0;
`ifdef CPU_DECODE_FORWARD_EN
    i_wb_valid = 1'b0; i_wb_rd_idx = '0; i_wb_rd = '0;
`endif
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hDEAD_BEEF;
    regs[2] = 32'h0001_0400;

    // Reset behaviour
    #1 i_reset_n = 1'b0;
    i_fetch_valid = 1'b1;
    repeat (3) @(negedge i_clock);
    chk("reset_fetch_ready", W'(o_fetch_ready), W'(0));
    chk("reset_exec", dut_bundle(), W'(0));
    chk("reset_read", W'({o_exec_valid, o_read, o_read_rs1_idx, o_read_rs2_idx, o_dbg_state}), W'(0));
    i_fetch_valid = 1'b0;
    i_reset_n = 1'b1;

    // addi x5,x2,16 with execute stalled
    send(32'h0101_0293, 32'h100, 1);
    chk("t1_read_strobe", W'(o_read), W'(1));
    chk("t1_rs1_idx", W'(o_read_rs1_idx), W'(2));
    chk("t1_valid_early", W'(o_exec_valid), W'(0));
    @(posedge i_clock); #1;
    chk("t1_read_one_cycle", W'(o_read), W'(0));
    chk("t1_valid_early2", W'(o_exec_valid), W'(0));
    @(posedge i_clock); #1;
    chk("t1_valid", W'(o_exec_valid), W'(1));
    chk("t1_rs1", W'(o_exec_rs1), W'(32'h0001_0400));
    chk("t1_imm", W'(o_exec_imm), W'(32'h10));
    chk("t1_rd", W'(o_exec_rd_idx), W'(5));
    chk("t1_op", W'(o_exec_op), W'(OP_ALU_I));
    chk("t1_pc", W'(o_exec_pc), W'(32'h100));

    // Offer add x1,x0,x0 while execute holds ready low for 5 cycles
    i_fetch_instruction = 32'h0000_00B3;
    i_fetch_pc          = 32'h104;
    i_fetch_valid       = 1'b1;
    repeat (5) begin
      @(negedge i_clock);
      chk("t2_fetch_blocked", W'(o_fetch_ready), W'(0));
    end
    rdy_mode = 2;
    @(negedge i_clock);
    chk("t2_ready_on_handoff", W'(o_fetch_ready), W'(1));
    exp_q.push_back(model(32'h0000_00B3, 32'h104));
    @(posedge i_clock); #1;
    i_fetch_valid = 1'b0;
    chk("t2_accept_on_handoff", W'(o_read), W'(1));
    wait_drain();

    // beq x0,x0,-4
    send(32'hFE00_0EE3, 32'h200, 1);
    wait_drain();

    // Flush in CAPTURE: no bundle, back to IDLE
    send(32'h0101_0293, 32'h300, 0);
    @(posedge i_clock); #1;
    i_flush = 1'b1;
    @(posedge i_clock); #1;
    i_flush = 1'b0;
    chk("flush_cap_valid", W'(o_exec_valid), W'(0));
    @(negedge i_clock);
    chk("flush_cap_ready", W'(o_fetch_ready), W'(1));

    // Flush in OUTPUT together with a fetch offer: no handoff, no accept
    rdy_mode = 0;
    send(32'h0101_0293, 32'h400, 0);
    @(posedge i_clock); #1;
    @(posedge i_clock); #1;
    chk("flush_out_valid_before", W'(o_exec_valid), W'(1));
    i_flush = 1'b1;
    i_fetch_instruction = 32'h0000_00B3;
    i_fetch_valid = 1'b1;
    @(negedge i_clock);
    chk("flush_out_no_ready", W'(o_fetch_ready), W'(0));
    @(posedge i_clock); #1;
    i_flush = 1'b0;
    i_fetch_valid = 1'b0;
    chk("flush_out_valid_after", W'(o_exec_valid), W'(0));
    chk("flush_out_no_accept", W'(o_read), W'(0));

    // All-zero word is illegal but still delivered
    rdy_mode = 2;
    send(32'h0000_0000, 32'h500, 1);
    wait_drain();

    // Reset in the middle of an instruction
    rdy_mode = 0;
    send(32'h0101_0293, 32'h600, 0);
    @(posedge i_clock); #3;
    i_reset_n = 1'b0;
    #1;
    chk("midreset_exec", dut_bundle(), W'(0));
    chk("midreset_ctrl", W'({o_exec_valid, o_fetch_ready, o_read, o_dbg_state}), W'(0));
    @(negedge i_clock);
    i_reset_n = 1'b1;
    @(posedge i_clock); #1;
    chk("midreset_no_output", W'(o_exec_valid), W'(0));

`ifdef CPU_DECODE_FORWARD_EN
    rdy_mode = 2;
    i_wb_valid = 1'b1; i_wb_rd_idx = 5'd2; i_wb_rd = 32'h1234;
    send(32'h0101_0293, 32'h700, 1);
    wait_drain();
    i_wb_rd_idx = 5'd0;
    send(32'h0100_0293, 32'h704, 1);
    wait_drain();
    i_wb_valid = 1'b0;
`endif

    // Randomized traffic in blocks; regfile/writeback change only when drained
    for (int blk = 0; blk < 12; blk++) begin
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      rdy_mode = (blk % 3 == 2) ? 2 : 1;
`ifdef CPU_DECODE_FORWARD_EN
      i_wb_valid  = 1'($urandom_range(0, 1));
      i_wb_rd_idx = 5'($urandom_range(0, 31));
      i_wb_rd     = $urandom;
`endif
      for (int t = 0; t < 20; t++) begin
        send(rand_instr(), $urandom & 32'hFFFF_FFFC, 1);
        repeat ($urandom_range(0, 2)) @(posedge i_clock);
      end
      wait_drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
